// File: rtl/clk_gate_ctrl.sv
// Gate-enable controller for one gated clock domain: merges client wake requests,
// acks after a settle time, re-gates after an idle timeout and counts gate-off events.
module clk_gate_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8,
  parameter int CNT_W    = $clog2(((WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC) + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               force_on,
  output logic [NUM_REQ-1:0] ack,
  output logic               gate_en,
  output logic [1:0]         state,
  output logic [7:0]         gate_off_cnt
);

  // req/ack is a level handshake: a client holds req high for as long as it needs
  // the clock; ack is high only while that client's req is high and the domain is ON.
  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_WAKE = 2'b01,
    S_ON   = 2'b10,
    S_IDLE = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gate_en_q, gate_en_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [7:0]         gate_off_cnt_q, gate_off_cnt_d;
  logic               any_req;

  assign any_req = (|req) | force_on;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    gate_off_cnt_d = gate_off_cnt_q;
    case (state_q)
      S_OFF: begin
        if (any_req) begin
          state_d = S_WAKE;
          cnt_d   = CNT_W'(WAKE_CYC - 1);
        end
      end
      S_WAKE: begin
        // A dropped request does not abort the wake; we always pass through ON.
        if (cnt_q == '0) state_d = S_ON;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ON: begin
        if (!any_req) begin
          state_d = S_IDLE;
          cnt_d   = CNT_W'(IDLE_CYC - 1);
        end
      end
      S_IDLE: begin
        // The clock never stopped, so a request here returns to ON with no settle time.
        if (any_req) begin
          state_d = S_ON;
        end else if (cnt_q == '0) begin
          state_d = S_OFF;
          if (gate_off_cnt_q != 8'hFF) gate_off_cnt_d = gate_off_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_OFF;
    endcase
    gate_en_d = (state_d != S_OFF);
    ack_d     = req & {NUM_REQ{state_d == S_ON}};
  end

  // gate_en comes straight from a flop so the latch cell never sees a glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_OFF;
      cnt_q          <= '0;
      gate_en_q      <= 1'b0;
      ack_q          <= '0;
      gate_off_cnt_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      gate_en_q      <= gate_en_d;
      ack_q          <= ack_d;
      gate_off_cnt_q <= gate_off_cnt_d;
    end
  end

  assign ack          = ack_q;
  assign gate_en      = gate_en_q;
  assign state        = state_q;
  assign gate_off_cnt = gate_off_cnt_q;

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Clock-gate controller that owns the `en` input of the latch-based `clk_gating` cell for one gated clock domain. It collects wake requests from up to `NUM_REQ` clients and asserts a registered, glitch-free gate enable. It acknowledges each client only after a programmable wake-up settle time. It also re-gates the domain after a programmable number of idle cycles. A status counter records the number of gate-off events for power profiling.

## Interface
- `NUM_REQ`, 4: number of requesters (1..16).
- `WAKE_CYC`, 2: cycles between `gate_en` rising and the first `ack` (>= 1).
- `IDLE_CYC`, 8: idle cycles with no request before `gate_en` falls (>= 1).
- `CNT_W`, `$clog2(max(WAKE_CYC,IDLE_CYC)+1)`: width of the internal down-counter.

- `clk`  in  1  free-running ungated clock; the same clock that feeds the gating cell.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  per-client level request; the clock is needed while high.
- `force_on`  in  1  debug override; keeps the domain clocked and never acks.
- `ack`  out  NUM_REQ  per-client grant; the gated clock is stable and usable.
- `gate_en`  out  1  registered enable to `clk_gating.en`.
- `state`  out  2  current FSM state: OFF=00, WAKE=01, ON=10, IDLE=11.
- `gate_off_cnt`  out  8  count of ON→OFF transitions through IDLE; saturates at 255.

## Operation
- Define `any_req = |req | force_on`.
- All outputs are registered. Reset values are: `state`=OFF, `gate_en`=0, `ack`=0, `gate_off_cnt`=0, internal `cnt`=0.
- OFF:
  - `gate_en`=0, `ack`=0.
  - If `any_req`: go to WAKE with `cnt<=WAKE_CYC-1`.
- WAKE:
  - `gate_en`=1, `ack`=0.
  - If `cnt==0`: go to ON. Otherwise decrement `cnt`.
  - A request dropped during WAKE does not abort the wake; the FSM still passes through ON.
- ON:
  - `gate_en`=1.
  - If `any_req`: stay in ON. Otherwise go to IDLE with `cnt<=IDLE_CYC-1`.
- IDLE:
  - `gate_en`=1, `ack`=0.
  - If `any_req`: return to ON. There is no wake delay because the clock never stopped.
  - Else if `cnt==0`: go to OFF, `gate_en<=0`, and increment `gate_off_cnt` (saturating).
  - Otherwise decrement `cnt`.
- `ack[i]` is updated every edge: `ack[i] <= req[i] & (next_state==ON)`. Consequences:
  - `ack` falls one edge after `req[i]` falls.
  - New requesters arriving while in ON are acked one edge after `req[i]` is sampled.
- `force_on` alone drives the FSM into ON and holds it there with `ack`=0.
- `gate_en` is driven only from a flop clocked by `clk`; it never glitches. The downstream latch cell provides the low-phase hold.
- Reset mid-operation:
  - `gate_en` and `ack` drop immediately (asynchronously) and `state` returns to OFF.
  - `gate_off_cnt` clears; a reset is not counted as a gate-off event.

## Timing
- Cold wake:
  - `req` is sampled high at edge E0.
  - At E0: `gate_en`=1, `state`=WAKE.
  - At E0+WAKE_CYC: `state`=ON and `ack` asserted.
  - With defaults, `ack` rises 2 edges after `gate_en`.
- Warm request (already in ON or IDLE): `ack` is asserted at the first edge that samples `req`.
- Gate-off:
  - The last request is sampled low at edge E0, so E0 enters IDLE.
  - `gate_en` falls at E0+IDLE_CYC (IDLE lasts exactly IDLE_CYC cycles).
  - `gate_off_cnt` updates on the same edge.
- A request and the IDLE expiry in the same cycle: the request wins. The FSM goes to ON, with no gate-off and no count.
- OFF and `any_req` in the same cycle as `rst` deassertion: the request is sampled on the first edge after reset release.

## Test plan
Defaults apply to all scenarios: NUM_REQ=4, WAKE_CYC=2, IDLE_CYC=8.
1. Reset:
   - Assert `rst` between edges while in ON with `ack`=0001.
   - Required: `gate_en`=0, `ack`=0000, `state`=00 and `gate_off_cnt`=0 with no clock edge.
2. Cold wake:
   - `req`=0001 sampled at E0.
   - Required: `gate_en`=1 and `state`=01 after E0; `ack`=0001 and `state`=10 after E2; `ack`=0000 before E2.
3. Idle timeout:
   - Drop `req` to 0000, sampled at Ek.
   - Required: `ack`=0000 and `state`=11 after Ek; `gate_en` falls after Ek+8; `gate_off_cnt` goes 0→1; `state`=00.
4. Re-request in IDLE:
   - `req`=0100 sampled on the 5th IDLE cycle.
   - Required: `state`=10 and `ack`=0100 after that edge; `gate_en` never drops; `gate_off_cnt` unchanged.
   - Repeat with `req` arriving exactly on the expiry cycle: same result.
5. Force-on:
   - `force_on`=1 with `req`=0000 for 50 cycles.
   - Required: `gate_en`=1 from the first edge; `ack`=0000 throughout; `state` settles at 10.
   - Release `force_on`: `gate_en` falls 8 edges later.
6. Counter saturation and reset mid-WAKE:
   - Run 300 wake/idle cycles. Required: `gate_off_cnt`=255.
   - Assert `rst` one cycle into WAKE. Required: `gate_en`=0 immediately, `ack` never asserts, and the next `req` restarts a full 2-cycle wake.
